// File: rtl/and_gate.sv
// and_gate: bitwise two-input AND with a zero-latency output and a clocked
// observation side. The side provides a registered copy, per-bit edge pulses
// and a saturating count of cycles in which any output bit was true.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall,
    output logic [CNT_W-1:0] true_cnt
);

    logic out_any;
    logic cnt_sat;

    // The gate itself. X/Z propagate through the plain operator, and a 0 on
    // either input forces 0, so no squashing is done here.
    assign out     = inp1 & inp2;
    assign out_any = |out;
    assign cnt_sat = &true_cnt;

    // Registered copy plus edge pulses. Each pulse is computed from the
    // pre-edge out_q, so a pulse coincides with out_q taking its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_rise <= '0;
            out_fall <= '0;
        end else begin
            out_q    <= out;
            out_rise <= out & ~out_q;
            out_fall <= ~out & out_q;
        end
    end

    // Output-true counter: clear has priority, and it stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            true_cnt <= '0;
        end else if (clr) begin
            true_cnt <= '0;
        end else if (out_any && !cnt_sat) begin
            true_cnt <= true_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate. It uses three instances: a default instance,
// a 3-bit counter instance for saturation, and a 4-bit wide instance.
module tb_and_gate;

    logic clk;
    logic rst_n;

    logic       a_i1, a_i2, a_clr;
    logic       a_out, a_q, a_rise, a_fall;
    logic [15:0] a_cnt;

    logic       s_i1, s_i2, s_clr;
    logic       s_out, s_q, s_rise, s_fall;
    logic [2:0] s_cnt;

    logic [3:0] w_i1, w_i2;
    logic       w_clr;
    logic [3:0] w_out, w_q, w_rise, w_fall;
    logic [15:0] w_cnt;

    int checks;
    int errors;

    and_gate u_a (
        .clk(clk), .rst_n(rst_n), .inp1(a_i1), .inp2(a_i2), .clr(a_clr),
        .out(a_out), .out_q(a_q), .out_rise(a_rise), .out_fall(a_fall),
        .true_cnt(a_cnt)
    );

    and_gate #(.WIDTH(1), .CNT_W(3)) u_s (
        .clk(clk), .rst_n(rst_n), .inp1(s_i1), .inp2(s_i2), .clr(s_clr),
        .out(s_out), .out_q(s_q), .out_rise(s_rise), .out_fall(s_fall),
        .true_cnt(s_cnt)
    );

    and_gate #(.WIDTH(4), .CNT_W(16)) u_w (
        .clk(clk), .rst_n(rst_n), .inp1(w_i1), .inp2(w_i2), .clr(w_clr),
        .out(w_out), .out_q(w_q), .out_rise(w_rise), .out_fall(w_fall),
        .true_cnt(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_i1 = 0; a_i2 = 0; a_clr = 0;
        s_i1 = 0; s_i2 = 0; s_clr = 0;
        w_i1 = '0; w_i2 = '0; w_clr = 0;
        #1;

        // Reset state
        check("rst_out_q", 32'(a_q), 32'd0);
        check("rst_rise", 32'(a_rise), 32'd0);
        check("rst_fall", 32'(a_fall), 32'd0);
        check("rst_cnt", 32'(a_cnt), 32'd0);

        // Truth table, combinational, while reset is held low
        a_i1 = 0; a_i2 = 0; #1; check("tt_00", 32'(a_out), 32'd0);
        #9; a_i1 = 0; a_i2 = 1; #1; check("tt_01", 32'(a_out), 32'd0);
        #9; a_i1 = 1; a_i2 = 1; #1; check("tt_11", 32'(a_out), 32'd1);
        #9; a_i1 = 1; a_i2 = 0; #1; check("tt_10", 32'(a_out), 32'd0);
        a_i1 = 0; a_i2 = 0;

        @(negedge clk);
        rst_n = 1'b1;

        // Registered path: rise
        a_i1 = 1; a_i2 = 1;
        tick();
        check("reg_q1", 32'(a_q), 32'd1);
        check("reg_rise1", 32'(a_rise), 32'd1);
        check("reg_fall1", 32'(a_fall), 32'd0);
        check("reg_cnt1", 32'(a_cnt), 32'd1);
        tick();
        check("reg_rise_once", 32'(a_rise), 32'd0);
        check("reg_q_hold", 32'(a_q), 32'd1);
        check("reg_fall_none", 32'(a_fall), 32'd0);

        // Registered path: fall
        a_i2 = 0;
        tick();
        check("fall_q0", 32'(a_q), 32'd0);
        check("fall_pulse", 32'(a_fall), 32'd1);
        check("fall_norise", 32'(a_rise), 32'd0);
        check("fall_cnt_hold", 32'(a_cnt), 32'd2);
        tick();
        check("fall_once", 32'(a_fall), 32'd0);

        // Counter
        a_clr = 1; tick(); a_clr = 0;
        check("clr_zero", 32'(a_cnt), 32'd0);
        a_i1 = 1; a_i2 = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("cnt_up", 32'(a_cnt), 32'(i));
        end
        a_i1 = 0; a_i2 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt_hold", 32'(a_cnt), 32'd5);
        end
        a_i1 = 1; a_i2 = 1; a_clr = 1;
        tick();
        a_clr = 0;
        check("clr_wins", 32'(a_cnt), 32'd0);

        // Reset mid-operation with cnt=4, out_q=1
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_cnt", 32'(a_cnt), 32'd4);
        check("pre_rst_q", 32'(a_q), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(a_q), 32'd0);
        check("mid_rst_rise", 32'(a_rise), 32'd0);
        check("mid_rst_fall", 32'(a_fall), 32'd0);
        check("mid_rst_cnt", 32'(a_cnt), 32'd0);
        check("mid_rst_out", 32'(a_out), 32'd1);
        tick();
        check("rst_hold_q", 32'(a_q), 32'd0);
        check("rst_hold_cnt", 32'(a_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_rise", 32'(a_rise), 32'd1);
        check("rel_q", 32'(a_q), 32'd1);
        check("rel_cnt", 32'(a_cnt), 32'd1);

        // Saturation with a 3-bit counter
        s_i1 = 1; s_i2 = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sat_cnt", 32'(s_cnt), (i > 7) ? 32'd7 : 32'(i));
        end
        s_clr = 1; tick(); s_clr = 0;
        check("sat_clr", 32'(s_cnt), 32'd0);

        // Width 4
        w_i1 = 4'b1100; w_i2 = 4'b1010; #1;
        check("w_out", 32'(w_out), 32'h8);
        tick();
        check("w_q", 32'(w_q), 32'h8);
        check("w_rise", 32'(w_rise), 32'h8);
        check("w_fall", 32'(w_fall), 32'h0);
        w_i2 = 4'b0101; #1;
        check("w_out2", 32'(w_out), 32'h4);
        tick();
        check("w_rise2", 32'(w_rise), 32'h4);
        check("w_fall2", 32'(w_fall), 32'h8);
        check("w_cnt", 32'(w_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_gate.md
# and_gate

Bitwise two-input AND primitive with a clocked observation side. The `out` path is purely combinational and matches the plain gate's truth table. A registered copy, one-cycle edge pulses and a saturating "output-true" cycle counter let downstream logic and benches sample the gate synchronously. It is a leaf cell used wherever a gated enable needs both a zero-latency and a registered form.

## Interface
- `WIDTH`, default 1: bit width of `inp1`, `inp2`, `out` and every per-bit output.
- `CNT_W`, default 16: width of `true_cnt`.

- `clk`  input  1  system clock; all registers update on the rising edge.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `inp1`  input  WIDTH  operand A.
- `inp2`  input  WIDTH  operand B.
- `clr`  input  1  synchronous clear of `true_cnt`, active-high.
- `out`  output  WIDTH  combinational `inp1 & inp2`.
- `out_q`  output  WIDTH  `out` registered on `clk`.
- `out_rise`  output  WIDTH  per-bit one-cycle pulse on a 0→1 transition of `out_q`.
- `out_fall`  output  WIDTH  per-bit one-cycle pulse on a 1→0 transition of `out_q`.
- `true_cnt`  output  CNT_W  saturating count of clock edges at which `out != 0`.

## Operation
- `out = inp1 & inp2`, bitwise, purely combinational.
  - `out` has no dependence on `clk` or `rst_n`.
  - `out` is valid while `rst_n` is low.
- Truth table per bit:
  - 0,0 → 0
  - 0,1 → 0
  - 1,1 → 1
  - 1,0 → 0
- Every rising `clk` edge with `rst_n` high performs these updates:
  - `out_q <= out`.
  - `out_rise <= out & ~out_q`, using the pre-edge value of `out_q`.
  - `out_fall <= ~out & out_q`, using the pre-edge value of `out_q`.
  - If `clr` is 1: `true_cnt <= 0`.
  - Else if `out != 0` and `true_cnt` is not all-ones: `true_cnt <= true_cnt + 1`.
  - Else: `true_cnt` holds.
- `clr` has priority over increment when both apply on the same edge.
- `true_cnt` saturates at 2^CNT_W − 1 and never wraps.
- `out_rise` and `out_fall` are never both 1 on the same bit.
- X or Z on an input propagates per standard AND semantics. A 0 on either input forces 0. No X-squashing is performed.

## Timing
- `out`: zero-cycle latency (combinational only).
- `out_q`: 1-cycle latency from an input change that is stable before the edge.
- `out_rise` / `out_fall`:
  - Asserted in the cycle after the edge where `out` differed from the old `out_q`.
  - Coincide with the edge on which `out_q` takes its new value.
  - Each pulse lasts exactly 1 cycle.
- `true_cnt`: reflects the edge that sampled `out` in the following cycle.
- Asynchronous reset (`rst_n` falling, at any time, including mid-count):
  - Immediately forces `out_q`, `out_rise`, `out_fall` and `true_cnt` to 0.
  - Those outputs hold at 0 while `rst_n` is low.
- Reset release: first update occurs on the first rising `clk` after `rst_n` goes high.
- An input already at 1/1 during reset produces `out_rise` = 1 one cycle after release, because `out_q` was 0.

## Test plan
- Truth-table sweep, no clock needed:
  - Stimulus: inp1/inp2 = 0/0, then 0/1 after 10 ns, 1/1 after 20 ns, 1/0 after 30 ns.
  - Required: `out` reads 0, 0, 1, 0 with zero delay.
- Registered path:
  - Stimulus: 1/1 applied before edge N.
  - Required: `out_q` = 1 from edge N; `out_rise` = 1 for exactly the cycle following edge N; `out_fall` stays 0.
  - Stimulus: then drop `inp2`.
  - Required: `out_fall` gives a single 1-cycle pulse and `out_q` returns to 0.
- Counter:
  - Stimulus: hold 1/1 for 5 edges, then 0/1 for 3 edges.
  - Required: `true_cnt` = 5 and stays 5.
  - Stimulus: assert `clr` together with 1/1.
  - Required: `true_cnt` = 0 (clear wins).
- Saturation:
  - Stimulus: `CNT_W` = 3, hold 1/1 for 10 edges.
  - Required: `true_cnt` stops at 7 and never wraps to 0.
- Reset mid-operation:
  - Stimulus: with `true_cnt` = 4 and `out_q` = 1, pull `rst_n` low between edges.
  - Required: all registered outputs read 0 immediately; `out` still equals `inp1 & inp2`.
  - Stimulus: release `rst_n` with 1/1 held.
  - Required: `out_rise` pulses on the first edge.
- Width:
  - Stimulus: `WIDTH` = 4, `inp1` = 4'b1100, `inp2` = 4'b1010.
  - Required: `out` = 4'b1000; per-bit rise only on bit 3.
